// File: rtl/mmio_timer.sv
// Memory-mapped one-shot down-counting timer with a programmable prescaler.
// Single-cycle registered bus: every cycle with cs high is acknowledged one cycle later.
module mmio_timer #(
   parameter logic [31:0] NAME0   = 32'h746d6572,
   parameter logic [31:0] VERSION = 32'h00000001
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cs,
   input  logic        we,
   input  logic [7:0]  address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic        running,
   output logic        expired
);

   localparam logic [7:0] AddrName0   = 8'h00;
   localparam logic [7:0] AddrVersion = 8'h02;
   localparam logic [7:0] AddrCtrl    = 8'h08;
   localparam logic [7:0] AddrStatus  = 8'h09;
   localparam logic [7:0] AddrPresc   = 8'h0a;
   localparam logic [7:0] AddrTimer   = 8'h0b;

   logic [31:0] prescaler_q;
   logic [31:0] timer_q;     // TIMER register doubles as the live down-counter
   logic [31:0] pre_ctr_q;
   logic        running_q;
   logic        expired_q;
   logic        ready_q;
   logic [31:0] read_data_q;

   logic        bus_wr;
   logic        bus_rd;
   logic        ctrl_wr;
   logic        stop_req;
   logic        start_req;
   logic        final_tick;
   logic [31:0] presc_eff;
   logic [31:0] rd_mux;

   always_comb begin
      bus_wr     = cs & we;
      bus_rd     = cs & ~we;
      ctrl_wr    = bus_wr && (address == AddrCtrl);
      stop_req   = ctrl_wr && write_data[1];
      start_req  = ctrl_wr && write_data[0] && !write_data[1] && !running_q
                   && (timer_q != 32'd0);
      presc_eff  = (prescaler_q == 32'd0) ? 32'd1 : prescaler_q;
      final_tick = running_q && (pre_ctr_q <= 32'd1) && (timer_q == 32'd1);
   end

   always_comb begin
      rd_mux = 32'h0;
      case (address)
         AddrName0:   rd_mux = NAME0;
         AddrVersion: rd_mux = VERSION;
         AddrStatus:  rd_mux = {31'h0, running_q};
         AddrPresc:   rd_mux = prescaler_q;
         AddrTimer:   rd_mux = timer_q;
         default:     rd_mux = 32'h0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prescaler_q <= 32'h0;
         timer_q     <= 32'h0;
         pre_ctr_q   <= 32'h0;
         running_q   <= 1'b0;
         expired_q   <= 1'b0;
         ready_q     <= 1'b0;
         read_data_q <= 32'h0;
      end else begin
         ready_q     <= cs;
         read_data_q <= bus_rd ? rd_mux : 32'h0;
         // A stop landing on the final count suppresses the pulse but still lets t_ctr reach 0.
         expired_q   <= final_tick && !stop_req;

         if (running_q) begin
            if (pre_ctr_q > 32'd1) begin
               pre_ctr_q <= pre_ctr_q - 32'd1;
            end else begin
               pre_ctr_q <= presc_eff;
               if (timer_q != 32'd0) begin
                  timer_q <= timer_q - 32'd1;
               end
            end
            if (stop_req || final_tick) begin
               running_q <= 1'b0;
            end
         end else begin
            if (start_req) begin
               pre_ctr_q <= presc_eff;
               running_q <= 1'b1;
            end
            if (bus_wr && (address == AddrPresc)) begin
               prescaler_q <= write_data;
            end
            if (bus_wr && (address == AddrTimer)) begin
               timer_q <= write_data;
            end
         end
      end
   end

   assign read_data = read_data_q;
   assign ready     = ready_q;
   assign running   = running_q;
   assign expired   = expired_q;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: bus protocol, register map, counting, stop and reset cases.
module tb_mmio_timer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cs = 1'b0;
   logic        we = 1'b0;
   logic [7:0]  address = 8'h0;
   logic [31:0] write_data = 32'h0;
   logic [31:0] read_data;
   logic        ready;
   logic        running;
   logic        expired;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [7:0] AName = 8'h00, AVer = 8'h02, ACtrl = 8'h08, AStat = 8'h09;
   localparam logic [7:0] APre = 8'h0a, ATim = 8'h0b;

   mmio_timer dut (
      .clk       (clk),
      .reset     (reset),
      .cs        (cs),
      .we        (we),
      .address   (address),
      .write_data(write_data),
      .read_data (read_data),
      .ready     (ready),
      .running   (running),
      .expired   (expired)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One bus cycle; returns #1 after the edge so the response is visible.
   task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d);
      cs = 1'b1; we = w; address = a; write_data = d;
      @(posedge clk); #1;
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic tick();
      cs = 1'b0; we = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
      bus(1'b0, a, 32'h0);
      check({tag, "_rdy"}, {31'h0, ready}, 32'd1);
      check(tag, read_data, exp);
   endtask

   initial begin
      bit saw_exp;

      // Reset with a simultaneous PRESCALER write
      @(posedge clk); #1;
      reset = 1'b1;
      bus(1'b1, APre, 32'd5);
      check("rst_ready", {31'h0, ready}, 32'd0);
      check("rst_rdata", read_data, 32'h0);
      check("rst_running", {31'h0, running}, 32'd0);
      check("rst_expired", {31'h0, expired}, 32'd0);
      reset = 1'b0;
      rd_check("rst_presc", APre, 32'h0);
      rd_check("rst_timer", ATim, 32'h0);

      // NAME0 with cs held three cycles
      cs = 1'b1; we = 1'b0; address = AName;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("name_rdy", {31'h0, ready}, 32'd1);
         check("name_data", read_data, 32'h746d6572);
      end
      tick();
      check("name_rdy_end", {31'h0, ready}, 32'd0);
      check("name_data_end", read_data, 32'h0);

      rd_check("version", AVer, 32'h1);
      rd_check("ctrl_rd", ACtrl, 32'h0);
      rd_check("unmapped_rd", 8'h05, 32'h0);
      bus(1'b1, 8'h05, 32'hdeadbeef);
      check("wr_rdy", {31'h0, ready}, 32'd1);
      check("wr_rdata", read_data, 32'h0);
      rd_check("unmapped_rd2", 8'h05, 32'h0);
      bus(1'b1, APre, 32'h1234_5678);
      rd_check("presc_rw", APre, 32'h1234_5678);

      // P=0, T=1
      bus(1'b1, APre, 32'd0);
      bus(1'b1, ATim, 32'd1);
      bus(1'b1, ACtrl, 32'h1);
      check("p0_run", {31'h0, running}, 32'd1);
      check("p0_exp0", {31'h0, expired}, 32'd0);
      tick();
      check("p0_run_end", {31'h0, running}, 32'd0);
      check("p0_exp1", {31'h0, expired}, 32'd1);
      tick();
      check("p0_exp_end", {31'h0, expired}, 32'd0);
      rd_check("p0_timer", ATim, 32'h0);

      // P=3, T=4: read TIMER every running cycle
      bus(1'b1, APre, 32'd3);
      bus(1'b1, ATim, 32'd4);
      bus(1'b1, ACtrl, 32'h1);
      check("p3_run1", {31'h0, running}, 32'd1);
      for (int k = 1; k <= 12; k++) begin
         bus(1'b0, ATim, 32'h0);
         check("p3_timer", read_data, 32'(4 - (k - 1) / 3));
         check("p3_run", {31'h0, running}, (k + 1 <= 12) ? 32'd1 : 32'd0);
         check("p3_exp", {31'h0, expired}, (k + 1 == 13) ? 32'd1 : 32'd0);
      end
      tick();
      check("p3_exp_end", {31'h0, expired}, 32'd0);

      // Writes ignored while running, then stop
      bus(1'b1, APre, 32'd10);
      bus(1'b1, ATim, 32'd5);
      bus(1'b1, ACtrl, 32'h1);
      rd_check("stat_run", AStat, 32'h1);
      bus(1'b1, ATim, 32'd99);
      bus(1'b1, APre, 32'd7);
      bus(1'b1, ACtrl, 32'h2);
      check("stop_run", {31'h0, running}, 32'd0);
      check("stop_exp", {31'h0, expired}, 32'd0);
      tick();
      check("stop_exp2", {31'h0, expired}, 32'd0);
      rd_check("stop_timer", ATim, 32'd5);
      rd_check("stop_presc", APre, 32'd10);
      rd_check("stat_idle", AStat, 32'h0);

      // Start with TIMER=0, and CTRL=3 while idle
      bus(1'b1, ATim, 32'd0);
      bus(1'b1, ACtrl, 32'h1);
      check("t0_run", {31'h0, running}, 32'd0);
      tick();
      check("t0_exp", {31'h0, expired}, 32'd0);
      bus(1'b1, ATim, 32'd2);
      bus(1'b1, ACtrl, 32'h3);
      check("both_run", {31'h0, running}, 32'd0);
      rd_check("both_timer", ATim, 32'd2);

      // Stop on the final count: no pulse, counter reaches 0
      bus(1'b1, APre, 32'd0);
      bus(1'b1, ACtrl, 32'h1);
      tick();
      bus(1'b1, ACtrl, 32'h2);
      check("fin_run", {31'h0, running}, 32'd0);
      check("fin_exp", {31'h0, expired}, 32'd0);
      tick();
      check("fin_exp2", {31'h0, expired}, 32'd0);
      rd_check("fin_timer", ATim, 32'd0);

      // Reset mid-count
      bus(1'b1, APre, 32'd2);
      bus(1'b1, ATim, 32'd10);
      bus(1'b1, ACtrl, 32'h1);
      for (int i = 0; i < 3; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mrst_run", {31'h0, running}, 32'd0);
      check("mrst_exp", {31'h0, expired}, 32'd0);
      check("mrst_rdy", {31'h0, ready}, 32'd0);
      check("mrst_rdata", read_data, 32'h0);
      saw_exp = 1'b0;
      for (int i = 0; i < 25; i++) begin
         tick();
         if (expired) saw_exp = 1'b1;
      end
      check("mrst_no_exp", {31'h0, saw_exp}, 32'd0);
      rd_check("mrst_presc", APre, 32'h0);
      rd_check("mrst_timer", ATim, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
